// File: rtl/taptempo_pkg.sv
// Shared constants, width helpers and FSM encoding for the tap-tempo blocks.
package taptempo_pkg;

    localparam int BPM_MAX    = 250;
    localparam int TP_PER_MIN = 60000;

    function automatic int bpm_width(input int bpm_max);
        return $clog2(bpm_max + 1);
    endfunction

    function automatic int cnt_width(input int tp_per_min);
        return $clog2(tp_per_min + 1);
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DIV   = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/divider_serial.sv
// Restoring unsigned divider, one quotient bit per cycle, start/done handshake.
module divider_serial #(
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] quotient_o,
    output logic              done_o
);

    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W:0]   rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] dsr;
    logic [CW-1:0]     step;
    logic              busy;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W:0]   diff;
    logic              take;

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    always_comb begin
        rem_sh = {rem[DATA_W-1:0], quo[DATA_W-1]};
        diff   = rem_sh - {1'b0, dsr};
        take   = (rem_sh >= {1'b0, dsr});
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rem    <= '0;
            quo    <= '0;
            dsr    <= '0;
            step   <= '0;
            busy   <= 1'b0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (start_i) begin
                rem  <= '0;
                quo  <= dividend_i;
                dsr  <= divisor_i;
                step <= CW'(DATA_W);
                busy <= 1'b1;
            end else if (busy) begin
                rem  <= take ? diff : rem_sh;
                quo  <= {quo[DATA_W-2:0], take};
                step <= step - CW'(1);
                if (step == CW'(1)) begin
                    busy   <= 1'b0;
                    done_o <= 1'b1;
                end
            end
        end
    end

    assign quotient_o = quo;

endmodule

// File: rtl/bpm_calc.sv
// Tap-tempo BPM calculator: measures tp_i periods between taps and divides.
// Define BPM_AVERAGE_EN to average the last four periods before dividing.
module bpm_calc
    import taptempo_pkg::*;
#(
    parameter int BPM_MAX    = taptempo_pkg::BPM_MAX,
    parameter int TP_PER_MIN = taptempo_pkg::TP_PER_MIN
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          tp_i,
    input  logic                          btn_i,
    output logic [bpm_width(BPM_MAX)-1:0] bpm_o,
    output logic                          bpm_valid
);

    localparam int W  = cnt_width(TP_PER_MIN);
    localparam int BW = bpm_width(BPM_MAX);
`ifdef BPM_AVERAGE_EN
    localparam int DW = W + 2;
    localparam logic [DW-1:0] DIVIDEND = DW'(4 * TP_PER_MIN);
`else
    localparam int DW = W;
    localparam logic [DW-1:0] DIVIDEND = DW'(TP_PER_MIN);
`endif

    state_e        state, state_nxt;
    logic [W-1:0]  cnt;
    logic          latch, go_div, div_start, div_done, div_zero;
    logic [DW-1:0] divisor, quotient;

    function automatic logic [BW-1:0] sat_bpm(input logic [DW-1:0] q);
        if (q > DW'(BPM_MAX))
            return BW'(BPM_MAX);
        return q[BW-1:0];
    endfunction

    assign latch = (state == COUNT) && btn_i;

    // Any tap restarts the period; a tp_i coinciding with the tap is dropped.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            cnt <= '0;
        else if (btn_i)
            cnt <= '0;
        else if (tp_i && (cnt != W'(TP_PER_MIN)))
            cnt <= cnt + W'(1);
    end

`ifdef BPM_AVERAGE_EN
    logic [W-1:0] hist [4];
    logic [2:0]   hist_n;
    logic         start_q;

    // History shifts on the tap; the divider starts a cycle later on the new sum.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < 4; i++)
                hist[i] <= '0;
            hist_n  <= '0;
            start_q <= 1'b0;
        end else begin
            start_q <= go_div;
            if (latch) begin
                hist[0] <= cnt;
                for (int i = 1; i < 4; i++)
                    hist[i] <= hist[i-1];
                if (hist_n != 3'd4)
                    hist_n <= hist_n + 3'd1;
            end
        end
    end

    assign go_div    = latch && (hist_n >= 3'd3);
    assign div_start = start_q;
    assign divisor   = DW'(hist[0]) + DW'(hist[1]) + DW'(hist[2]) + DW'(hist[3]);
`else
    assign go_div    = latch;
    assign div_start = latch;
    assign divisor   = cnt;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            div_zero <= 1'b0;
        else if (div_start)
            div_zero <= (divisor == '0);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (btn_i)    state_nxt = COUNT;
            COUNT:   if (go_div)   state_nxt = DIV;
            DIV:     if (div_done) state_nxt = DONE;
            DONE:                  state_nxt = COUNT;
            default:               state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            bpm_o     <= '0;
            bpm_valid <= 1'b0;
        end else begin
            bpm_valid <= (state == DONE);
            if (state == DONE)
                bpm_o <= div_zero ? BW'(BPM_MAX) : sat_bpm(quotient);
        end
    end

    divider_serial #(
        .DATA_W(DW)
    ) u_div (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .start_i    (div_start),
        .dividend_i (DIVIDEND),
        .divisor_i  (divisor),
        .quotient_o (quotient),
        .done_o     (div_done)
    );

endmodule

// File: tb/tb_bpm_calc.sv
// Directed scoreboard bench for bpm_calc (default build and BPM_AVERAGE_EN build).
module tb_bpm_calc;

`ifdef BPM_AVERAGE_EN
    localparam longint LAT = 21;
`else
    localparam longint LAT = 18;
`endif

    typedef struct {
        int     bpm;
        longint cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       tp;
    logic       btn;
    logic [7:0] bpm;
    logic       bpm_valid;

    exp_t   sb[$];
    longint cyc    = 0;
    int     nvalid = 0;
    int     total  = 0;
    int     bad    = 0;

    bpm_calc dut (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .tp_i      (tp),
        .btn_i     (btn),
        .bpm_o     (bpm),
        .bpm_valid (bpm_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_bpm(input int p);
        int p2;
        int q;
        p2 = (p > 60000) ? 60000 : p;
        if (p2 == 0)
            return 250;
        q = 60000 / p2;
        return (q > 250) ? 250 : q;
    endfunction

    // Scoreboard: every strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rstn && bpm_valid) begin
            exp_t e;
            nvalid <= nvalid + 1;
            chk("strobe_expected", longint'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("bpm_value", longint'(bpm), longint'(e.bpm));
                chk("latency", cyc - e.cyc, LAT);
            end
        end
    end

    task automatic period(input int n);
        repeat (n) begin
            @(negedge clk);
            tp = 1'b1;
        end
    endtask

    task automatic tap(input bit with_tp, input bit expect_res, input int exp_val);
        exp_t e;
        @(negedge clk);
        btn = 1'b1;
        tp  = with_tp;
        @(negedge clk);
        btn = 1'b0;
        tp  = 1'b0;
        if (expect_res) begin
            e.bpm = exp_val;
            e.cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("drain_timeout", longint'(sb.size()), 0);
    endtask

    task automatic measure(input int n);
        period(n);
        tap(1'b0, 1'b1, exp_bpm(n));
        drain();
    endtask

    initial begin
        int nv;
        rstn = 1'b0;
        tp   = 1'b0;
        btn  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_bpm", longint'(bpm), 0);
        chk("reset_valid", longint'(bpm_valid), 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        tap(1'b0, 1'b0, 0);
        repeat (30) @(negedge clk);
        chk("first_tap_no_valid", longint'(nvalid), 0);

`ifdef BPM_AVERAGE_EN
        period(500);
        tap(1'b0, 1'b0, 0);
        period(500);
        tap(1'b0, 1'b0, 0);
        period(1000);
        tap(1'b0, 1'b0, 0);
        repeat (40) @(negedge clk);
        chk("avg_no_valid_before_4", longint'(nvalid), 0);
        period(1000);
        tap(1'b0, 1'b1, 80);
        drain();
        chk("avg_one_valid", longint'(nvalid), 1);
        chk("avg_bpm_held", longint'(bpm), 80);
`else
        measure(500);
        measure(1000);
        repeat (10) @(negedge clk);
        chk("bpm_held", longint'(bpm), 60);
        measure(100);
        measure(500);
        measure(0);
        measure(60050);

        // Third tap lands during the division: one strobe, quotient unchanged.
        period(500);
        tap(1'b0, 1'b1, 120);
        repeat (4) @(negedge clk);
        nv = nvalid;
        tap(1'b0, 1'b0, 0);
        drain();
        repeat (10) @(negedge clk);
        chk("div_tap_one_valid", longint'(nvalid - nv), 1);
        chk("div_tap_bpm", longint'(bpm), 120);
        measure(1000);

        // tp_i coinciding with the tap belongs to neither period.
        period(400);
        tap(1'b1, 1'b1, 150);
        drain();
        measure(600);

        // Asynchronous reset in the middle of a division.
        period(500);
        tap(1'b0, 1'b0, 0);
        repeat (5) @(negedge clk);
        nv = nvalid;
        rstn = 1'b0;
        #1;
        chk("abort_bpm", longint'(bpm), 0);
        chk("abort_valid", longint'(bpm_valid), 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_no_valid", longint'(nvalid - nv), 0);
        tap(1'b0, 1'b0, 0);
        repeat (30) @(negedge clk);
        chk("abort_first_tap", longint'(nvalid - nv), 0);
        measure(1000);
        chk("post_abort_bpm", longint'(bpm), 60);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bpm_calc.md
BPM_CALC -- requirements
Module: bpm_calc

Interface
REQ-001 SHALL have parameter BPM_MAX, default 250, meaning the saturation ceiling of the output BPM value.
REQ-002 SHALL have parameter TP_PER_MIN, default 60000, meaning the number of tp_i pulses per minute (1 ms timepulse).
REQ-003 SHALL have port clk_i  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rstn_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port tp_i  input  1  timepulse, one clk_i cycle wide.
REQ-006 SHALL have port btn_i  input  1  debounced tap, one clk_i cycle wide per press.
REQ-007 SHALL have port bpm_o  output  clog2(BPM_MAX+1)  last computed tempo, held between updates.
REQ-008 SHALL have port bpm_valid  output  1  one-cycle strobe, high when bpm_o carries a new value.

Function
REQ-009 SHALL count tp_i pulses in a period counter of width W = clog2(TP_PER_MIN+1), saturating at TP_PER_MIN with no wrap.
REQ-010 SHALL use FSM states IDLE, COUNT, DIV and DONE; reset enters IDLE.
REQ-011 In IDLE, btn_i SHALL clear the counter and go to COUNT with no division and no bpm_valid; this is the first tap after reset.
REQ-012 In COUNT, btn_i SHALL latch the counter as divisor, clear the counter in the same cycle, and go to DIV.
REQ-013 DIV SHALL run a restoring serial division TP_PER_MIN / divisor at one quotient bit per cycle for exactly W cycles, then go to DONE.
REQ-014 DONE SHALL load bpm_o, pulse bpm_valid for one cycle, and return to COUNT; the press-to-bpm_valid latency is W+2 cycles.
REQ-015 Divisor 0 (two taps in the same tp interval) SHALL skip the quotient and yield bpm_o = BPM_MAX.
REQ-016 A quotient greater than BPM_MAX SHALL saturate to BPM_MAX; a saturated counter yields quotient 1.
REQ-017 btn_i during DIV or DONE SHALL clear the counter but SHALL NOT start a new division or change the division in flight.
REQ-018 tp_i and btn_i in the same cycle SHALL clear the counter; that tp_i SHALL be counted in neither period.
REQ-019 The counter SHALL keep counting tp_i during DIV and DONE.

Reset
REQ-020 rstn_i low SHALL force, asynchronously: bpm_o=0, bpm_valid=0, counter=0, divider registers=0, state=IDLE.
REQ-021 Reset asserted during DIV SHALL abort the division; bpm_valid SHALL stay 0 until a new tap pair completes.

Configuration
REQ-022 Macro BPM_AVERAGE_EN, when defined, SHALL keep a 4-deep history of latched periods (shifted on each REQ-012 latch, cleared at reset).
REQ-023 With BPM_AVERAGE_EN, the divisor SHALL be the sum of the 4 entries, the dividend 4*TP_PER_MIN, and the divider width W+2.
REQ-024 With BPM_AVERAGE_EN, no bpm_valid SHALL occur until 4 periods are captured after reset.
REQ-025 Without BPM_AVERAGE_EN, the single-period behaviour of REQ-012 to REQ-016 SHALL apply, with no history registers present.

Structure
REQ-026 Shared package taptempo_pkg SHALL hold BPM_MAX, TP_PER_MIN, the width functions and the FSM state encoding.
REQ-027 The serial divider SHALL be a sub-module divider_serial, parameterised on width, with start/done handshake.

Verification
REQ-028 Taps 500 tp apart (after an initial tap) -> bpm_o=120, bpm_valid high exactly W+2 cycles after the second tap.
REQ-029 Taps 1000 tp apart -> bpm_o=60; taps 100 tp apart -> bpm_o=250 (saturated from 600).
REQ-030 Two taps with no tp_i between them -> bpm_o=250; 70000 tp between taps -> bpm_o=1.
REQ-031 First tap after reset -> no bpm_valid; third tap during DIV -> exactly one bpm_valid, unchanged quotient.
REQ-032 rstn_i pulsed low mid-DIV -> bpm_o=0, no bpm_valid, next tap treated as first.
REQ-033 BPM_AVERAGE_EN, periods 500,500,1000,1000 -> first bpm_valid only after the 4th period, bpm_o=80.
